pwm_multi: RTL and testbench

- Parametrised N-channel, WIDTH-bit PWM generator; successor to the single-channel 16-bit PWM.
- All channels share one programmable-period counter.
- Duty and period values are double-buffered and applied only at frame boundaries, so outputs never glitch.
- Written through a simple register write port; the I2C register bridge or the host-side logic drives this port.

---
 rtl/pwm_multi.sv | 133 +++++++++++++
 tb/tb_pwm_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM generator that shares one programmable-period counter.
// Duty and period values are written into shadow registers. They are copied to the
// active registers only on a frame wrap, so a frame never mixes old and new settings.
// Optional build macro PWM_MULTI_CENTER_ALIGNED_EN selects up/down (centre-aligned)
// counting. When the macro is undefined the counter is edge-aligned (up-count, then wrap).
module pwm_multi #(
    parameter int               WIDTH          = 16,
    parameter int               CHANNELS       = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = {WIDTH{1'b1}},
    parameter int               ADDR_BITS      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [CHANNELS-1:0]  out,
    output logic                 frame_start
);

    logic [WIDTH-1:0]    cnt_q;
    logic [WIDTH-1:0]    cnt_d;
    logic [WIDTH-1:0]    period_active_q;
    logic [WIDTH-1:0]    period_shadow_q;
    logic                frame_start_q;
    logic [CHANNELS-1:0] out_q;
    logic                wrap;
    logic                period_wr;

    // Address CHANNELS is the period shadow. Addresses above it match nothing, so those writes are dropped.
    assign period_wr = wr_en && (wr_addr == ADDR_BITS'(CHANNELS));

`ifdef PWM_MULTI_CENTER_ALIGNED_EN
    logic dir_q;   // 0 = counting up, 1 = counting down
    logic dir_d;

    // Up/down sequence 0..P..1. The wrap is the step back to 0, and P<=1 turns straight back to 0.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        wrap  = 1'b0;
        if (!dir_q) begin
            if (cnt_q == period_active_q) begin
                if (period_active_q <= WIDTH'(1)) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == WIDTH'(1)) begin
                cnt_d = '0;
                dir_d = 1'b0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Direction register. It restarts counting up after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Edge-aligned sequence 0..P, then wrap to 0.
    always_comb begin
        wrap  = (cnt_q == period_active_q);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
`endif

    // Shared counter, period double-buffer and frame-start flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q           <= '0;
            period_active_q <= DEFAULT_PERIOD;
            period_shadow_q <= DEFAULT_PERIOD;
            frame_start_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= (cnt_q == '0);
            if (period_wr) begin
                period_shadow_q <= wr_data;
            end
            if (wrap) begin
                period_active_q <= period_shadow_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] duty_shadow_q;
            logic [WIDTH-1:0] duty_active_q;
            logic             out_bit_q;
            logic             duty_wr;

            assign duty_wr   = wr_en && (wr_addr == ADDR_BITS'(gi));
            assign out_q[gi] = out_bit_q;

            // Per-channel duty double-buffer and registered compare against the shared counter.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    duty_shadow_q <= '0;
                    duty_active_q <= '0;
                    out_bit_q     <= 1'b0;
                end else begin
                    if (duty_wr) begin
                        duty_shadow_q <= wr_data;
                    end
                    if (wrap) begin
                        duty_active_q <= duty_shadow_q;
                    end
                    out_bit_q <= (cnt_q < duty_active_q);
                end
            end
        end
    endgenerate

    assign out         = out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed, table-driven bench for pwm_multi in the edge-aligned build.
// The bench measures one frame at a time, from one frame_start to the next.
// For each frame it records the frame length and the number of high cycles per channel.
// It also flags any channel whose high cycles are not one leading run.
module tb_pwm_multi;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int AB = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AB-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [CH-1:0] out;
    logic          frame_start;

    int n_checks = 0;
    int n_pass   = 0;
    int meas_len;
    int meas_hi[CH];
    bit meas_gap[CH];

    typedef struct packed {
        logic [8:0]          period;
        logic [CH-1:0][8:0]  duty;
        logic [8:0]          exp_len;
        logic [CH-1:0][8:0]  exp_hi;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    pwm_multi #(
        .WIDTH(W),
        .CHANNELS(CH),
        .DEFAULT_PERIOD(8'hFF),
        .ADDR_BITS(AB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .out(out),
        .frame_start(frame_start)
    );

    function automatic vec_t mkvec(input int p, input int d0, input int d1, input int d2, input int d3,
                                   input int len, input int h0, input int h1, input int h2, input int h3);
        vec_t v;
        v.period    = 9'(p);
        v.duty[0]   = 9'(d0);
        v.duty[1]   = 9'(d1);
        v.duty[2]   = 9'(d2);
        v.duty[3]   = 9'(d3);
        v.exp_len   = 9'(len);
        v.exp_hi[0] = 9'(h0);
        v.exp_hi[1] = 9'(h1);
        v.exp_hi[2] = 9'(h2);
        v.exp_hi[3] = 9'(h3);
        return v;
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge. The posedge that follows captures the write.
    task automatic do_write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = AB'(addr);
        wr_data = W'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Advance to the next negedge at which frame_start is high, with a bounded wait.
    task automatic wait_fs(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        check_val({name, "_fs_seen"}, int'(found), 1);
    endtask

    // Start at a negedge with frame_start high (k=0) and measure until the next frame_start.
    // An optional write is driven at sample index wr_at.
    task automatic measure_frame(input int wr_at, input int addr, input int data);
        bit seen_low[CH];
        meas_len = 0;
        for (int i = 0; i < CH; i++) begin
            meas_hi[i]  = 0;
            meas_gap[i] = 1'b0;
            seen_low[i] = 1'b0;
        end
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < CH; i++) begin
                if (out[i]) begin
                    meas_hi[i]++;
                    if (seen_low[i]) meas_gap[i] = 1'b1;
                end else begin
                    seen_low[i] = 1'b1;
                end
            end
            if (k == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = AB'(addr);
                wr_data = W'(data);
            end
            @(negedge clk);
            wr_en    = 1'b0;
            meas_len = k + 1;
            if (frame_start) break;
        end
    endtask

    // A gapped channel reports -1 so that it never matches an expected count.
    task automatic check_frame(input string name, input int len, input int h0, input int h1,
                               input int h2, input int h3);
        int exp_h[CH];
        exp_h[0] = h0; exp_h[1] = h1; exp_h[2] = h2; exp_h[3] = h3;
        check_val({name, "_len"}, meas_len, len);
        for (int i = 0; i < CH; i++) begin
            check_val($sformatf("%s_ch%0d_high", name, i), meas_gap[i] ? -1 : meas_hi[i], exp_h[i]);
        end
        $display("frame %s: len=%0d high=%0d,%0d,%0d,%0d", name, meas_len,
                 meas_hi[0], meas_hi[1], meas_hi[2], meas_hi[3]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mkvec(9,   3,   0,   0,  0,   10,   3,   0,  0, 0);
        vecs[1] = mkvec(9,   3,   0,  10, 255,  10,   3,   0, 10, 10);
        vecs[2] = mkvec(4,   1,   2,   5,  4,    5,   1,   2,  5, 4);
        vecs[3] = mkvec(0,   0,   1,   2, 255,   1,   0,   1,  1, 1);
        vecs[4] = mkvec(255, 128, 255, 1,  0,  256, 128, 255,  1, 0);

        // Reset state, then the first frame after release uses the default period.
        @(negedge clk);
        @(negedge clk);
        check_val("reset_out", int'(out), 0);
        check_val("reset_fs", int'(frame_start), 0);
        reset = 1'b1;
        @(negedge clk);
        check_val("release_fs", int'(frame_start), 1);
        measure_frame(-1, 0, 0);
        check_frame("after_reset", 256, 0, 0, 0, 0);

        // Table-driven steady-state frames.
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < CH; c++) do_write(c, int'(vecs[v].duty[c]));
            do_write(CH, int'(vecs[v].period));
            wait_fs($sformatf("vec%0d_a", v));
            wait_fs($sformatf("vec%0d_b", v));
            measure_frame(-1, 0, 0);
            check_frame($sformatf("vec%0d", v), int'(vecs[v].exp_len),
                        int'(vecs[v].exp_hi[0]), int'(vecs[v].exp_hi[1]),
                        int'(vecs[v].exp_hi[2]), int'(vecs[v].exp_hi[3]));
        end

        // Known baseline for the corner-case sequences: P=9, duties 3,0,6,0.
        do_write(0, 3);
        do_write(1, 0);
        do_write(2, 6);
        do_write(3, 0);
        do_write(CH, 9);
        wait_fs("base_a");
        wait_fs("base_b");

        // A mid-frame duty change keeps the current pulse and applies at the next frame.
        measure_frame(2, 0, 7);
        check_frame("midwr_cur", 10, 3, 0, 6, 0);
        measure_frame(-1, 0, 0);
        check_frame("midwr_next", 10, 7, 0, 6, 0);

        // A write captured on the wrap edge (cnt=9) waits one whole frame.
        measure_frame(8, 0, 5);
        check_frame("wrapwr_cur", 10, 7, 0, 6, 0);
        measure_frame(-1, 0, 0);
        check_frame("wrapwr_next", 10, 7, 0, 6, 0);
        measure_frame(-1, 0, 0);
        check_frame("wrapwr_after", 10, 5, 0, 6, 0);

        // A period write while cnt=7: the current frame still runs to 9, and the next is 5 cycles.
        measure_frame(6, CH, 4);
        check_frame("perwr_cur", 10, 5, 0, 6, 0);
        measure_frame(-1, 0, 0);
        check_frame("perwr_next", 5, 5, 0, 5, 0);

        // Addresses above CHANNELS are ignored.
        do_write(6, 0);
        do_write(5, 0);
        wait_fs("badaddr_a");
        wait_fs("badaddr_b");
        measure_frame(-1, 0, 0);
        check_frame("badaddr", 5, 5, 0, 5, 0);

        // A one-cycle reset mid-frame clears everything and restarts at the default period.
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_val("pre_reset_ch0", int'(out[0]), 1);
        reset = 1'b0;
        @(negedge clk);
        check_val("midreset_out", int'(out), 0);
        check_val("midreset_fs", int'(frame_start), 0);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrelease_fs", int'(frame_start), 1);
        measure_frame(-1, 0, 0);
        check_frame("after_midreset", 256, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
